// File: rtl/comparator_bist_pkg.sv
// Shared types for the comparator BIST: FSM states, response flags and the
// reference comparison used by the golden model.
package comparator_bist_pkg;

  localparam int unsigned MAX_WIDTH = 16;
  localparam int unsigned LAT_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    FIN
  } state_t;

  typedef struct packed {
    logic eq;
    logic gr;
    logic less;
  } cmp_flags_t;

  // Unsigned comparison; narrower operands are zero-extended by the caller.
  function automatic cmp_flags_t expected_flags(input logic [MAX_WIDTH-1:0] a,
                                                input logic [MAX_WIDTH-1:0] b);
    cmp_flags_t f;
    f.eq   = (a == b);
    f.gr   = (a > b);
    f.less = (a < b);
    return f;
  endfunction

endpackage

// File: rtl/comparator_bist_if.sv
// Bus between the BIST engine and its environment: control/status plus the
// operand/response link to the comparator under test.
interface comparator_bist_if #(
  parameter int unsigned WIDTH = 4
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 eq;
  logic                 gr;
  logic                 less;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*WIDTH:0]     err_count;
  logic [WIDTH-1:0]     fail_a;
  logic [WIDTH-1:0]     fail_b;

  // Environment side: host request plus the comparator's responses.
  modport master (
    output start, eq, gr, less,
    input  a, b, busy, done, pass, err_count, fail_a, fail_b
  );

  // BIST engine side.
  modport slave (
    input  start, eq, gr, less,
    output a, b, busy, done, pass, err_count, fail_a, fail_b
  );

endinterface

// File: rtl/comparator_golden.sv
// Combinational reference: expected one-hot {eq,gr,less} for the driven operands.
module comparator_golden
  import comparator_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_flags_t       exp_flags_c
);

  assign exp_flags_c = expected_flags(MAX_WIDTH'(a), MAX_WIDTH'(b));

endmodule

// File: rtl/comparator_bist.sv
// Exhaustive sweep BIST for an external WIDTH-bit comparator with LAT-cycle
// response latency; reports error count, first failing vector and pass/fail.
module comparator_bist
  import comparator_bist_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  comparator_bist_if.slave  bus
);

  localparam int unsigned       IDX_W     = 2 * WIDTH;
  localparam int unsigned       CNT_W     = 2 * WIDTH + 1;
  localparam logic [LAT_W-1:0]  WAIT_LAST = LAT_W'((LAT >= 2) ? (LAT - 2) : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [LAT_W-1:0]   wait_q, wait_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d;
  logic [WIDTH-1:0]   fail_b_q, fail_b_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  cmp_flags_t         exp_flags_c;
  cmp_flags_t         resp_c;
  logic               mismatch_c;

  comparator_golden #(.WIDTH(WIDTH)) u_golden (
    .a           (a_q),
    .b           (b_q),
    .exp_flags_c (exp_flags_c)
  );

  // Expected value is always one-hot, so zero-hot/multi-hot responses mismatch.
  assign resp_c     = '{eq: bus.eq, gr: bus.gr, less: bus.less};
  assign mismatch_c = (resp_c != exp_flags_c);

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    wait_d   = wait_q;
    a_d      = a_q;
    b_d      = b_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    err_d    = err_q;
    busy_d   = busy_q;
    pass_d   = pass_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = DRIVE;
          index_d  = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          fail_a_d = '0;
          fail_b_d = '0;
          busy_d   = 1'b1;
        end
      end

      DRIVE: begin
        a_d     = index_q[IDX_W-1:WIDTH];
        b_d     = index_q[WIDTH-1:0];
        wait_d  = '0;
        state_d = (LAT > 1) ? WAIT : CHECK;
      end

      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = CHECK;
        end else begin
          wait_d = wait_q + LAT_W'(1);
        end
      end

      // Response sampled at the end of this cycle, LAT edges after a/b update.
      CHECK: begin
        if (mismatch_c) begin
          if (err_q != CNT_MAX) begin
            err_d = err_q + CNT_W'(1);
          end
          if (err_q == '0) begin
            fail_a_d = a_q;
            fail_b_d = b_q;
          end
        end
        index_d = index_q + IDX_W'(1);
        if (index_q == IDX_LAST) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = DRIVE;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      index_q  <= '0;
      wait_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      wait_q   <= wait_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.fail_a    = fail_a_q;
  assign bus.fail_b    = fail_b_q;
  assign bus.err_count = err_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;

endmodule

// File: doc/comparator_bist.md
COMPARATOR_BIST -- requirements
Module: comparator_bist

Interface
REQ-001 SHALL expose parameter WIDTH, default 4, operand width of the comparator under test.
REQ-002 SHALL expose parameter LAT, default 1, number of cycles (1..7) from operand change to valid comparator result.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to begin a sweep.
REQ-006 SHALL have ports a and b, output, WIDTH each, registered operands driven to the comparator.
REQ-007 SHALL have ports eq, gr and less, input, 1 each, comparator responses.
REQ-008 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-009 SHALL have port done, output, 1, single-cycle pulse at sweep end.
REQ-010 SHALL have port pass, output, 1, high after done when err_count is 0; held until next start.
REQ-011 SHALL have port err_count, output, 2*WIDTH+1, number of failing vectors.
REQ-012 SHALL have ports fail_a and fail_b, output, WIDTH each, operands of the first failing vector.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK and FIN.
REQ-014 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-015 SHALL on an accepted start clear err_count, pass, fail_a and fail_b, load vector index 0 and enter DRIVE.
REQ-016 SHALL in DRIVE register a = index[2W-1:W] and b = index[W-1:0], then enter WAIT.
REQ-017 SHALL stay in WAIT for LAT-1 cycles (0 when LAT=1), then enter CHECK.
REQ-018 SHALL in CHECK sample eq, gr and less exactly LAT cycles after the new a/b first appear on the ports.
REQ-019 SHALL flag a vector failing when {eq,gr,less} differs from the expected one-hot value (a==b, a>b or a<b, unsigned).
REQ-020 SHALL treat zero-hot and multi-hot responses as failures.
REQ-021 SHALL increment err_count on each failure, saturating at its maximum.
REQ-022 SHALL capture fail_a and fail_b only on the first failure of a sweep.
REQ-023 SHALL in CHECK increment the index and return to DRIVE, or enter FIN when the index wraps from 2^(2W)-1 to 0.
REQ-024 SHALL give each vector a period of LAT+1 cycles: the full sweep takes 2^(2W)*(LAT+1) cycles (512 for the defaults).
REQ-025 SHALL in FIN assert done for one cycle, set pass = (err_count==0), deassert busy and return to IDLE.
REQ-026 SHALL hold a and b at their last vector values while in IDLE.

Reset
REQ-027 SHALL on rst_n low immediately force state IDLE and set a, b, index, err_count, fail_a, fail_b, busy, done and pass to 0.
REQ-028 SHALL abandon an in-progress sweep on reset without asserting done; the next start SHALL begin at vector 0.

Structure
REQ-029 SHALL place the state enumeration and a function returning the expected {eq,gr,less} for (a,b) in package comparator_bist_pkg.
REQ-030 SHALL contain one sub-module, comparator_golden, a combinational reference model producing the expected flags; all other logic is flat.

Verification
REQ-031 SHALL cover a correct 4-bit comparator with a start pulse: done exactly 512 cycles after busy rises, pass=1, err_count=0.
REQ-032 SHALL cover a comparator with gr and less swapped: err_count=240, fail_a=0, fail_b=1, pass=0.
REQ-033 SHALL cover a comparator with eq stuck at 0: err_count=16, fail_a=0, fail_b=0.
REQ-034 SHALL cover start pulses at vector 10 and again at FIN: no restart, and the sweep count and results are unchanged.
REQ-035 SHALL cover rst_n low at vector 100: all outputs are 0 the same cycle, no done; a new start then gives pass=1 after 512 cycles.
REQ-036 SHALL cover LAT=2 with a one-register-delayed correct comparator: pass=1, sweep of 768 cycles.
